// File: rtl/deinterleaver_pp.sv
`default_nettype none
// ============================================================================
// Module   : deinterleaver_pp
// Brief    : Ping-pong block deinterleaver, row-major write / column-major read
// Revision : 1.0
// ============================================================================
module deinterleaver_pp #(
  parameter int DATA_W = 11,
  parameter int ROWS   = 8,
  parameter int COLS   = 1536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  input  logic              sof_in,
  input  logic [DATA_W-1:0] din,
  input  logic              byp,
  output logic [DATA_W-1:0] dout,
  output logic              en_out,
  output logic              sof_out,
  output logic              ovf,
  output logic              busy
);

  localparam int N      = ROWS * COLS;
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [ADDR_W-1:0] C_LAST     = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] C_ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] C_COLS     = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] C_WRAP     = ADDR_W'((ROWS - 1) * COLS - 1);
  localparam logic [ROW_W-1:0]  C_ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0]  C_ROW_ONE  = ROW_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_t;

  logic [DATA_W-1:0] r_mem0 [N];
  logic [DATA_W-1:0] r_mem1 [N];

  // write side
  logic [ADDR_W-1:0] r_wk;
  logic              r_wbank;
  logic [1:0]        r_full;
  logic [1:0]        r_mode;

  // read side
  state_t            r_state;
  logic              r_rbank;
  logic [ADDR_W-1:0] r_m;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_avalid;
  logic              r_afirst;
  logic              r_abank;
  logic              r_rmode;

  logic [ADDR_W-1:0] w_wk;
  logic              w_wfull;
  logic              w_wr;
  logic              w_done;
  logic              w_start;
  logic              w_sbank;
  logic [ADDR_W-1:0] w_naddr;
  logic [ROW_W-1:0]  w_nrow;

  // sof_in restarts the frame; the abandoned partial frame never marks its bank FULL
  assign w_wk    = sof_in ? '0 : r_wk;
  assign w_wfull = r_full[r_wbank];
  assign w_wr    = en_in && !w_wfull;

  assign w_done  = (r_state == S_READ) && (r_m == C_LAST);
  assign w_sbank = w_done ? ~r_rbank : r_rbank;
  assign w_start = ((r_state == S_IDLE) && r_full[r_rbank]) ||
                   (w_done && r_full[~r_rbank]);

  // column-major stride: +COLS per row, step back to the next column on row wrap
  always_comb begin
    w_naddr = r_raddr + C_COLS;
    w_nrow  = r_row + C_ROW_ONE;
    if (r_rmode) begin
      w_naddr = r_raddr + C_ONE;
      w_nrow  = '0;
    end else if (r_row == C_ROW_LAST) begin
      w_naddr = r_raddr - C_WRAP;
      w_nrow  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !r_wbank) r_mem0[w_wk] <= din;
    if (w_wr &&  r_wbank) r_mem1[w_wk] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wk     <= '0;
      r_wbank  <= 1'b0;
      r_full   <= '0;
      r_mode   <= '0;
      r_state  <= S_IDLE;
      r_rbank  <= 1'b0;
      r_m      <= '0;
      r_row    <= '0;
      r_raddr  <= '0;
      r_avalid <= 1'b0;
      r_afirst <= 1'b0;
      r_abank  <= 1'b0;
      r_rmode  <= 1'b0;
      dout     <= '0;
      en_out   <= 1'b0;
      sof_out  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (en_in) begin
        if (w_wfull) begin
          ovf <= 1'b1;
        end else begin
          if (w_wk == '0) r_mode[r_wbank] <= byp;
          if (w_wk == C_LAST) begin
            r_full[r_wbank] <= 1'b1;
            r_wbank         <= ~r_wbank;
            r_wk            <= '0;
          end else begin
            r_wk <= w_wk + C_ONE;
          end
        end
      end

      if (w_done) begin
        r_full[r_rbank] <= 1'b0;
        r_rbank         <= ~r_rbank;
      end

      if (w_start) begin
        r_state  <= S_READ;
        r_m      <= '0;
        r_row    <= '0;
        r_raddr  <= '0;
        r_avalid <= 1'b1;
        r_afirst <= 1'b1;
        r_abank  <= w_sbank;
        r_rmode  <= r_mode[w_sbank];
      end else if (w_done) begin
        r_state  <= S_IDLE;
        r_avalid <= 1'b0;
        r_afirst <= 1'b0;
      end else if (r_state == S_READ) begin
        r_m      <= r_m + C_ONE;
        r_row    <= w_nrow;
        r_raddr  <= w_naddr;
        r_afirst <= 1'b0;
      end

      // the registered RAM read doubles as the output register
      en_out  <= r_avalid;
      sof_out <= r_avalid && r_afirst;
      if (r_avalid) dout <= r_abank ? r_mem1[r_raddr] : r_mem0[r_raddr];
    end
  end

  assign busy = (r_state == S_READ) || (|r_full);

endmodule
`default_nettype wire

// File: tb/tb_deinterleaver_pp.sv
`default_nettype none
// ============================================================================
// Module   : tb_deinterleaver_pp
// Brief    : Directed self-checking bench for deinterleaver_pp (4x6 and default)
// Revision : 1.0
// ============================================================================
module tb_deinterleaver_pp;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int C  = 6;
  localparam int N  = R * C;
  localparam int N6 = 8 * 1536;

  logic          clk = 1'b0;
  logic          rst, en_in, sof_in, byp;
  logic [DW-1:0] din, dout;
  logic          en_out, sof_out, ovf, busy;

  logic          en6, sof6, byp6;
  logic [10:0]   din6, dout6;
  logic          en_out6, sof_out6, ovf6, busy6;

  always #5 clk = ~clk;

  deinterleaver_pp #(.DATA_W(DW), .ROWS(R), .COLS(C)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .sof_in(sof_in), .din(din), .byp(byp),
    .dout(dout), .en_out(en_out), .sof_out(sof_out), .ovf(ovf), .busy(busy)
  );

  deinterleaver_pp dut6 (
    .clk(clk), .rst(rst), .en_in(en6), .sof_in(sof6), .din(din6), .byp(byp6),
    .dout(dout6), .en_out(en_out6), .sof_out(sof_out6), .ovf(ovf6), .busy(busy6)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] q_d[$];
  logic          q_s[$];
  int            q_c[$];

  always @(negedge clk) begin
    if (en_out) begin
      q_d.push_back(dout);
      q_s.push_back(sof_out);
      q_c.push_back(cyc);
    end
  end

  int          cnt6 = 0;
  int          sofs6 = 0;
  logic [10:0] v6_0, v6_1, v6_2, v6_8, v6_last;

  always @(negedge clk) begin
    if (en_out6) begin
      if (cnt6 == 0)      v6_0    = dout6;
      if (cnt6 == 1)      v6_1    = dout6;
      if (cnt6 == 2)      v6_2    = dout6;
      if (cnt6 == 8)      v6_8    = dout6;
      if (cnt6 == N6 - 1) v6_last = dout6;
      if (sof_out6) sofs6 = sofs6 + 1;
      cnt6 = cnt6 + 1;
    end
  end

  function automatic int tr(input int m);
    return (m % R) * C + m / R;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests = n_tests + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic s, input logic b);
    en_in  = 1'b1;
    din    = d;
    sof_in = s;
    byp    = b;
    tick();
    en_in  = 1'b0;
    sof_in = 1'b0;
    byp    = 1'b0;
  endtask

  task automatic clear_q();
    q_d.delete();
    q_s.delete();
    q_c.delete();
  endtask

  task automatic wait_q(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && q_d.size() < n; i++) tick();
    chk(tag, q_d.size(), n);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    clear_q();
  endtask

  int e;
  int nsof;

  initial begin
    rst = 1'b0; en_in = 1'b0; sof_in = 1'b0; byp = 1'b0; din = '0;
    en6 = 1'b0; sof6 = 1'b0; byp6 = 1'b0; din6 = '0;
    tick();
    tick();
    chk("rst_dout", dout, 0);
    chk("rst_en_out", en_out, 0);
    chk("rst_sof_out", sof_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    tick();

    // single transposed frame, half-rate input
    clear_q();
    for (int i = 0; i < N; i++) begin
      send(DW'(i), i == 0, 1'b0);
      if (i < N - 1) tick();
    end
    e = cyc;
    wait_q(N, 60, "t1_count");
    nsof = 0;
    for (int m = 0; m < q_d.size(); m++) begin
      chk("t1_dout", q_d[m], tr(m));
      if (q_s[m]) nsof++;
    end
    if (q_d.size() >= N) begin
      chk("t1_sof_first", q_s[0], 1);
      chk("t1_latency", q_c[0] - e, 2);
      chk("t1_contiguous", q_c[N-1] - q_c[0], N - 1);
    end
    chk("t1_sof_count", nsof, 1);
    repeat (5) tick();
    chk("t1_busy_idle", busy, 0);
    chk("t1_en_out_idle", en_out, 0);

    // normal frame followed back-to-back by a bypass frame
    clear_q();
    for (int i = 0; i < N; i++) begin
      send(DW'(i), i == 0, 1'b0);
      if (i < N - 1) tick();
    end
    for (int i = 0; i < N; i++) send(DW'(100 + i), i == 0, i == 0);
    wait_q(2 * N, 100, "t2_count");
    nsof = 0;
    for (int m = 0; m < q_d.size(); m++) begin
      chk("t2_dout", q_d[m], (m < N) ? tr(m) : 100 + m - N);
      if (q_s[m]) nsof++;
    end
    if (q_d.size() >= 2 * N) begin
      chk("t2_sof_frame2", q_s[N], 1);
      chk("t2_no_gap", q_c[2*N-1] - q_c[0], 2 * N - 1);
    end
    chk("t2_sof_count", nsof, 2);

    // sof_in mid-frame discards the partial frame
    repeat (5) tick();
    clear_q();
    for (int i = 0; i < 10; i++) send(DW'(i), i == 0, 1'b0);
    for (int i = 0; i < N; i++) send(DW'(50 + i), i == 0, 1'b0);
    wait_q(N, 80, "t3_count");
    repeat (40) tick();
    chk("t3_single_frame", q_d.size(), N);
    for (int m = 0; m < q_d.size(); m++) chk("t3_dout", q_d[m], 50 + tr(m));
    chk("t3_ovf", ovf, 0);

    // continuous input: 49th symbol hits the bank being released
    do_reset();
    for (int i = 0; i < 2 * N; i++) send(DW'(i), i == 0, 1'b0);
    chk("t4_ovf_before", ovf, 0);
    send(DW'(2 * N), 1'b0, 1'b0);
    chk("t4_ovf_set", ovf, 1);
    wait_q(2 * N, 100, "t4_count");
    repeat (40) tick();
    chk("t4_dropped", q_d.size(), 2 * N);
    for (int m = 0; m < q_d.size(); m++)
      chk("t4_dout", q_d[m], (m < N) ? tr(m) : N + tr(m - N));
    chk("t4_ovf_sticky", ovf, 1);
    do_reset();
    chk("t4_ovf_cleared", ovf, 0);

    // reset in the middle of a read
    for (int i = 0; i < N; i++) send(DW'(i), i == 0, 1'b0);
    wait_q(8, 60, "t5_partial");
    rst = 1'b0;
    tick();
    chk("t5_en_out", en_out, 0);
    chk("t5_busy", busy, 0);
    rst = 1'b1;
    clear_q();
    for (int i = 0; i < N; i++) send(DW'(200 + i), i == 0, 1'b0);
    wait_q(N, 60, "t5_count");
    for (int m = 0; m < q_d.size(); m++) chk("t5_dout", q_d[m], 200 + tr(m));
    if (q_s.size() > 0) chk("t5_sof", q_s[0], 1);

    // default geometry 8x1536
    for (int k = 0; k < N6; k++) begin
      en6  = 1'b1;
      din6 = 11'(k % 2048);
      sof6 = (k == 0);
      tick();
    end
    en6  = 1'b0;
    sof6 = 1'b0;
    for (int i = 0; i < N6 + 100 && cnt6 < N6; i++) tick();
    repeat (20) tick();
    chk("t6_count", cnt6, N6);
    chk("t6_dout0", v6_0, 0);
    chk("t6_dout1", v6_1, 1536);
    chk("t6_dout2", v6_2, 1024);
    chk("t6_dout8", v6_8, 1);
    chk("t6_dout_last", v6_last, 2047);
    chk("t6_sof_count", sofs6, 1);
    chk("t6_ovf", ovf6, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
